// File: rtl/shift_count_unit_pkg.sv
// Shared constants and types for the shift count unit.
//   WIDTH / CNT_W : default operand width and count width (CNT_W must hold WIDTH)
//   mode_e        : what is being counted (leading zeros, trailing zeros, sign bits)
//   state_e       : control FSM states
package shift_count_unit_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    MODE_LEAD,
    MODE_TRAIL,
    MODE_SIGN
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

endpackage

// File: rtl/shift_count_unit_step.sv
// One scan step of the count unit (purely combinational).
//   w      : current work value
//   c      : number of positions already examined
//   mode   : counting mode
//   stop   : scan terminates on this value
//   w_next : work value after one more shift (used only when stop is low)
module shift_count_unit_step
  import shift_count_unit_pkg::*;
#(
  parameter int unsigned WIDTH = shift_count_unit_pkg::WIDTH,
  parameter int unsigned CNT_W = shift_count_unit_pkg::CNT_W
) (
  input  logic [WIDTH-1:0] w,
  input  logic [CNT_W-1:0] c,
  input  mode_e            mode,
  output logic             stop,
  output logic [WIDTH-1:0] w_next
);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntSign = CNT_W'(WIDTH - 1);

  always_comb begin
    stop   = 1'b1;
    w_next = w;
    unique case (mode)
      MODE_LEAD: begin
        stop   = w[WIDTH-1] || (c == CntFull);
        w_next = w << 1;
      end
      MODE_TRAIL: begin
        stop   = w[0] || (c == CntFull);
        w_next = w >> 1;
      end
      MODE_SIGN: begin
        // At most WIDTH-1 redundant copies of the sign can exist.
        stop   = (w[WIDTH-1] != w[WIDTH-2]) || (c == CntSign);
        w_next = w << 1;
      end
      default: begin
        stop   = 1'b1;
        w_next = w;
      end
    endcase
  end

endmodule

// File: rtl/shift_count_unit.sv
// Iterative leading-zero / trailing-zero / redundant-sign-bit counter.
// Examines one bit position per cycle and returns the count plus the operand
// normalized by that count.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   Start               : request; Input/Type/Direction sampled when accepted
//   Input               : operand
//   Type                : 0 = zero count, 1 = redundant sign-bit count
//   Direction           : zero count only: 0 = leading, 1 = trailing
//   Busy                : count in progress
//   Done                : one-cycle pulse when Count/Normalized update
//   Count, Normalized   : result, held until the next completion or reset
module shift_count_unit
  import shift_count_unit_pkg::*;
#(
  parameter int unsigned WIDTH = shift_count_unit_pkg::WIDTH,
  parameter int unsigned CNT_W = shift_count_unit_pkg::CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Input,
  input  logic             Type,
  input  logic             Direction,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Normalized
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_in;
  logic [WIDTH-1:0] work_q, work_next;
  logic [CNT_W-1:0] cnt_q;
  logic             stop;
  logic             accept, finish;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] norm_q;

  assign mode_in = Type ? MODE_SIGN : (Direction ? MODE_TRAIL : MODE_LEAD);

  shift_count_unit_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .w      (work_q),
    .c      (cnt_q),
    .mode   (mode_q),
    .stop   (stop),
    .w_next (work_next)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is only honoured outside SCAN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = Start ? SCAN : IDLE;
      SCAN:       state_d = stop ? DONE : SCAN;
      default:    state_d = IDLE;
    endcase
  end

  // Output / datapath control.
  always_comb begin
    accept = (state_q != SCAN) && Start;
    finish = (state_q == SCAN) && stop;
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LEAD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      norm_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        work_q <= Input;
        cnt_q  <= '0;
        mode_q <= mode_in;
      end else if ((state_q == SCAN) && !stop) begin
        work_q <= work_next;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (finish) begin
        count_q <= cnt_q;
        norm_q  <= work_q;
      end
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Count      = count_q;
  assign Normalized = norm_q;

endmodule

// File: tb/tb_shift_count_unit.sv
module tb_shift_count_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [31:0] Input;
  logic        Type;
  logic        Direction;
  logic        Busy;
  logic        Done;
  logic [5:0]  Count;
  logic [31:0] Normalized;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  shift_count_unit dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Input      (Input),
    .Type       (Type),
    .Direction  (Direction),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count),
    .Normalized (Normalized)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Counts Done-high cycles, sampled mid-cycle.
  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] op, input logic typ, input logic dir);
    @(negedge Clk);
    Input     = op;
    Type      = typ;
    Direction = dir;
    Start     = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Counts edges until Done is seen; flags any pre-Done cycle without Busy.
  task automatic wait_done(input int limit, output int cyc, output int busy_bad);
    cyc = 0;
    busy_bad = 0;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (Done === 1'b1) break;
      if (Busy !== 1'b1) busy_bad++;
      if (cyc >= limit) break;
    end
  endtask

  int cyc, bb, d0;

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Input = '0; Type = 1'b0; Direction = 1'b0;
    #12;
    chk("rst_busy",  64'(Busy), 64'd0);
    chk("rst_done",  64'(Done), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_norm",  64'(Normalized), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Leading zeros of 1.
    start_op(32'h0000_0001, 1'b0, 1'b0);
    chk("lead1_busy_start", 64'(Busy), 64'd1);
    wait_done(40, cyc, bb);
    chk("lead1_lat",   64'(cyc), 64'd32);
    chk("lead1_busy",  64'(bb), 64'd0);
    chk("lead1_count", 64'(Count), 64'd31);
    chk("lead1_norm",  64'(Normalized), 64'h8000_0000);
    chk("lead1_busy_done", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    chk("lead1_done_pulse", 64'(Done), 64'd0);
    chk("lead1_hold", 64'(Count), 64'd31);

    // Trailing zeros of 0 and of MSB-only.
    start_op(32'h0000_0000, 1'b0, 1'b1);
    chk("hold_on_start", 64'(Count), 64'd31);
    wait_done(40, cyc, bb);
    chk("trail0_lat",   64'(cyc), 64'd33);
    chk("trail0_busy",  64'(bb), 64'd0);
    chk("trail0_count", 64'(Count), 64'd32);
    chk("trail0_norm",  64'(Normalized), 64'h0);
    start_op(32'h8000_0000, 1'b0, 1'b1);
    wait_done(40, cyc, bb);
    chk("trail31_lat",   64'(cyc), 64'd32);
    chk("trail31_count", 64'(Count), 64'd31);
    chk("trail31_norm",  64'(Normalized), 64'h0000_0001);

    // Redundant sign bits; Direction must be ignored.
    start_op(32'hFFFF_F000, 1'b1, 1'b1);
    wait_done(40, cyc, bb);
    chk("sign_lat",   64'(cyc), 64'd20);
    chk("sign_count", 64'(Count), 64'd19);
    chk("sign_norm",  64'(Normalized), 64'h8000_0000);
    start_op(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(40, cyc, bb);
    chk("signff_lat",   64'(cyc), 64'd32);
    chk("signff_count", 64'(Count), 64'd31);
    chk("signff_norm",  64'(Normalized), 64'h8000_0000);
    start_op(32'h0000_0000, 1'b1, 1'b0);
    wait_done(40, cyc, bb);
    chk("sign00_count", 64'(Count), 64'd31);
    chk("sign00_norm",  64'(Normalized), 64'h0);
    start_op(32'h3000_0000, 1'b1, 1'b0);
    wait_done(40, cyc, bb);
    chk("sign3_count", 64'(Count), 64'd1);
    chk("sign3_norm",  64'(Normalized), 64'h6000_0000);

    // Zero-count result, then a Start held into the DONE cycle.
    start_op(32'h8000_0000, 1'b0, 1'b0);
    Input = 32'h0000_00FF; Type = 1'b0; Direction = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    chk("b2b_first_done",  64'(Done), 64'd1);
    chk("b2b_first_count", 64'(Count), 64'd0);
    chk("b2b_first_norm",  64'(Normalized), 64'h8000_0000);
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("b2b_accept_busy", 64'(Busy), 64'd1);
    chk("b2b_accept_done", 64'(Done), 64'd0);
    wait_done(40, cyc, bb);
    chk("b2b_lat",   64'(cyc), 64'd25);
    chk("b2b_count", 64'(Count), 64'd24);
    chk("b2b_norm",  64'(Normalized), 64'hFF00_0000);

    // Start during SCAN is ignored.
    @(posedge Clk); #1;
    d0 = done_cnt;
    start_op(32'h0001_0000, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Input = 32'h0000_0001; Type = 1'b1; Direction = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(40, cyc, bb);
    chk("ign_lat",   64'(cyc), 64'd12);
    chk("ign_count", 64'(Count), 64'd15);
    chk("ign_norm",  64'(Normalized), 64'h8000_0000);
    repeat (40) @(posedge Clk);
    #1;
    chk("ign_one_done", 64'(done_cnt - d0), 64'd1);
    chk("ign_idle_busy", 64'(Busy), 64'd0);

    // Asynchronous reset mid-scan.
    start_op(32'h0000_0001, 1'b0, 1'b0);
    repeat (5) @(posedge Clk);
    #3;
    d0 = done_cnt;
    Rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(Busy), 64'd0);
    chk("arst_done",  64'(Done), 64'd0);
    chk("arst_count", 64'(Count), 64'd0);
    chk("arst_norm",  64'(Normalized), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("arst_idle", 64'(Busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
